serial_nibble_rx: RTL and testbench
===================================

Name: serial_nibble_rx

Overview:
- Serial-to-parallel receiver for asynchronous frames carrying one WIDTH-bit nibble.
- Recovers the nibble from a single serial line, checks parity and framing, and presents the result on data with a one-cycle valid strobe.
- Sits directly upstream of the 4-bit ff register and drives its d input; the register captures data on the clk edge where valid is high.

Parameters:
- WIDTH, 4: data bits per frame, sent LSB first.
- BIT_CYCLES, 4: clk cycles per serial bit period; legal values are 2..255. H = BIT_CYCLES/2 (integer division).
- PARITY_EN, 1: 1 = a parity bit follows the data bits; 0 = no parity bit (P = 0, otherwise P = 1).
- PARITY_ODD, 0: 0 = even parity; 1 = odd parity.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- rx  in  1  asynchronous serial line; idles high.
- data  out  WIDTH  last accepted nibble.
- valid  out  1  one-cycle pulse: data updated this cycle.
- parity_err  out  1  one-cycle pulse, coincident with valid, when the parity check fails.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- busy  out  1  high while a frame is in progress or while waiting for the line to return high.

Behaviour:
- Reset and clock
  - Only clock is clk. Reset is asynchronous and active-low: reset_n low clears state immediately, independent of clk.
  - Reset values: data=0, valid=0, parity_err=0, frame_err=0, busy=0, state=IDLE, all counters 0, both synchronizer flops=1.
- Synchronizer
  - rx passes through a 2-flop synchronizer; s is the synchronizer output, lagging rx by 2 cycles.
  - All decisions below use s only.
- States: IDLE, START, DATA, PARITY (skipped when PARITY_EN=0), STOP, WAIT_HIGH.
- Sample schedule
  - t0 is the first cycle in IDLE with s=0. busy goes high at t0+1.
  - Start check at t0+H:
    - s=1: glitch; return to IDLE, no outputs pulse, busy drops the next cycle.
    - s=0: go to DATA.
  - Data bit i (i=0..WIDTH-1) is sampled at t0+H+(i+1)*BIT_CYCLES and shifted in LSB first.
  - Parity bit is sampled at t0+H+(WIDTH+1)*BIT_CYCLES.
  - Stop bit is sampled at t0+H+(WIDTH+1+P)*BIT_CYCLES.
- Stop-bit outcome (outputs registered, asserted on the cycle after the stop sample)
  - Stop=1: data takes the assembled nibble, valid=1.
    - parity_err=1 when the XOR of the data bits and the parity bit is not equal to PARITY_ODD; data is still delivered.
    - FSM returns to IDLE; busy=0 on that same cycle.
    - A new frame may start immediately: s=0 on the first IDLE cycle is a valid t0.
  - Stop=0: frame_err=1, valid=0, data holds its previous value, parity_err=0. FSM enters WAIT_HIGH.
    - In WAIT_HIGH, busy stays 1 until the first cycle s=1, then the FSM goes to IDLE.
- Output rules
  - valid, parity_err and frame_err are never high for more than one consecutive cycle.
  - data changes only in a cycle where valid=1.
- Reset mid-frame: a partial nibble is discarded; no pulse is generated after reset_n rises.
- rx changes between samples are ignored; there is no majority voting.
- Frame length is (2+WIDTH+P)*BIT_CYCLES cycles; with the defaults this is 28.

Test Plan:
- Defaults; hold rx=1 for 20 cycles after reset -> data=0, valid, parity_err, frame_err and busy all stay 0 throughout.
- Send start, bits 0,0,1,1, parity 0, stop 1 (each bit 4 cycles) -> exactly one valid pulse with data=4'b1100, parity_err=0. valid occurs 2 (synchronizer) + H + 6*4 + 1 cycles after rx falls.
- Send nibble 4'b0101 with parity bit 1 (wrong for even parity) -> valid=1 with data=4'b0101 and parity_err=1 in the same cycle. Repeat with parity bit 0 -> parity_err=0.
- Send 4'b1111 with correct parity and stop bit 0, rx held low 8 more cycles, then high -> frame_err pulses once, valid=0, data remains 4'b0101. busy stays high until 1 cycle after s returns high, and no spurious frame starts.
- rx low for 1 cycle only -> no valid or error pulse; busy high for at most H+1 cycles, then 0. Follow with a full 4'b1010 frame -> received correctly.
- Two back-to-back frames 4'b0011 and 4'b1001 with no idle gap -> two valid pulses exactly 28 cycles apart with correct data.
- Pull reset_n low mid-DATA -> outputs reset immediately, with no valid after release. The next complete frame is received correctly.

Source files
------------

// File: rtl/serial_nibble_rx.sv
// Asynchronous serial frame receiver: start bit, WIDTH data bits LSB first,
// optional parity bit, stop bit. Delivers the nibble with a one-cycle valid strobe.
module serial_nibble_rx #(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 4,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  localparam int H  = BIT_CYCLES / 2;
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t           state_reg, state_next;
  logic             sync1_reg, sync2_reg;
  logic [7:0]       cnt_reg, cnt_next;
  logic [BW-1:0]    bit_reg, bit_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic             par_reg, par_next;
  logic [WIDTH-1:0] data_next;
  logic             valid_next, perr_next, ferr_next;
  logic             s, bit_tick, half_tick;

  assign s         = sync2_reg;
  assign bit_tick  = (cnt_reg == 8'(BIT_CYCLES));
  assign half_tick = (cnt_reg == 8'(H));

  // State register, synchronizer and registered output pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      sync1_reg  <= 1'b1;
      sync2_reg  <= 1'b1;
      cnt_reg    <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      par_reg    <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sync1_reg  <= rx;
      sync2_reg  <= sync1_reg;
      cnt_reg    <= cnt_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      par_reg    <= par_next;
      data       <= data_next;
      valid      <= valid_next;
      parity_err <= perr_next;
      frame_err  <= ferr_next;
    end
  end

  // Next-state logic. cnt_reg equals the number of cycles since the last
  // sample point, so every sample lands exactly BIT_CYCLES after the previous.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 8'd1;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!s) begin
          state_next = START;
          cnt_next   = 8'd1;
          bit_next   = '0;
          par_next   = 1'b0;
        end
      end
      START: begin
        if (half_tick) begin
          cnt_next   = s ? 8'd0 : 8'd1;
          state_next = s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_next = {s, shift_reg[WIDTH-1:1]};
          cnt_next   = 8'd1;
          bit_next   = bit_reg + 1'b1;
          if (bit_reg == BW'(WIDTH - 1))
            state_next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_tick) begin
          par_next   = s;
          cnt_next   = 8'd1;
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          cnt_next   = '0;
          state_next = s ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        cnt_next = '0;
        if (s) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output logic: pulse values for the cycle after the stop sample.
  always_comb begin
    busy       = (state_reg != IDLE);
    valid_next = (state_reg == STOP) && bit_tick && s;
    ferr_next  = (state_reg == STOP) && bit_tick && !s;
    perr_next  = valid_next && (PARITY_EN != 0) &&
                 ((^shift_reg ^ par_reg) != (PARITY_ODD != 0));
    data_next  = valid_next ? shift_reg : data;
  end

endmodule

// File: tb/tb_serial_nibble_rx.sv
// Scoreboard bench for serial_nibble_rx: stimulus queues expected pulses,
// a negedge monitor pops and compares them as the DUT strobes.
module tb_serial_nibble_rx;

  localparam int BC      = 4;
  localparam int H       = BC / 2;
  localparam int LATENCY = 2 + H + 6 * BC + 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx;
  logic [3:0] data;
  logic       valid, parity_err, frame_err, busy;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    bit       is_valid;
    bit [3:0] data;
    bit       perr;
    int       cyc;
  } exp_t;
  exp_t q[$];

  serial_nibble_rx #(.WIDTH(4), .BIT_CYCLES(BC), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  logic       prev_valid = 1'b0, prev_ferr = 1'b0;
  logic [3:0] prev_data  = 4'h0;
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (valid) chk("valid_single_cycle", prev_valid, 0);
      if (frame_err) chk("ferr_single_cycle", prev_ferr, 0);
      if (parity_err) chk("perr_with_valid", valid, 1);
      if (data !== prev_data) chk("data_change_needs_valid", valid, 1);
      if (valid || frame_err) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", {valid, frame_err}, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          $display("frame: valid=%0b ferr=%0b data=%b perr=%0b cyc=%0d (exp data=%b perr=%0b cyc=%0d)",
                   valid, frame_err, data, parity_err, cyc, e.data, e.perr, e.cyc);
          chk("pulse_valid", valid, e.is_valid);
          chk("pulse_ferr", frame_err, !e.is_valid);
          chk("data", data, e.data);
          chk("parity_err", parity_err, e.perr);
          chk("pulse_cycle", cyc, e.cyc);
        end
      end
    end
    prev_valid <= valid;
    prev_ferr  <= frame_err;
    prev_data  <= data;
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BC) @(posedge clk);
    #1;
  endtask

  // Drives a full frame starting now; expectation is pushed before the start bit.
  task automatic send_frame(input logic [3:0] nib, input logic par, input logic stop,
                            input bit exp_valid, input logic [3:0] exp_data, input bit exp_perr);
    exp_t e;
    e.is_valid = exp_valid;
    e.data     = exp_data;
    e.perr     = exp_perr;
    e.cyc      = cyc + LATENCY;
    q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(nib[i]);
    send_bit(par);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int bcnt;
    rx      = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Idle line after reset: everything stays quiet
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("rst_data", data, 0);
      chk("rst_valid", valid, 0);
      chk("rst_perr", parity_err, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_busy", busy, 0);
    end

    // Bits 0,0,1,1 with even parity 0
    send_frame(4'b1100, 1'b0, 1'b1, 1, 4'b1100, 0);
    idle(6);
    // Wrong parity, then correct parity
    send_frame(4'b0101, 1'b1, 1'b1, 1, 4'b0101, 1);
    idle(6);
    send_frame(4'b0101, 1'b0, 1'b1, 1, 4'b0101, 0);
    idle(6);

    // Framing error: stop low and line held low 8 more cycles
    send_frame(4'b1111, 1'b0, 1'b0, 0, 4'b0101, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("wait_high_busy", busy, 1);
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("wait_high_busy_until_s_high", busy, 1);
    @(posedge clk); #1;
    chk("wait_high_release", busy, 0);
    idle(40);
    chk("no_spurious_start", busy, 0);

    // One-cycle glitch
    rx = 1'b0;
    @(posedge clk); #1;
    rx   = 1'b1;
    bcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
    end
    chk("glitch_busy_seen", bcnt > 0, 1);
    chk("glitch_busy_bounded", bcnt <= H + 1, 1);
    chk("glitch_busy_low", busy, 0);
    send_frame(4'b1010, 1'b0, 1'b1, 1, 4'b1010, 0);
    idle(6);

    // Back-to-back frames, no idle gap
    send_frame(4'b0011, 1'b0, 1'b1, 1, 4'b0011, 0);
    send_frame(4'b1001, 1'b0, 1'b1, 1, 4'b1001, 0);
    idle(8);

    // Reset in the middle of the data bits
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    reset_n = 1'b0;
    #1;
    chk("midrst_data", data, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_perr", parity_err, 0);
    chk("midrst_ferr", frame_err, 0);
    chk("midrst_busy", busy, 0);
    rx = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(40);
    chk("post_rst_idle_busy", busy, 0);
    send_frame(4'b0111, 1'b1, 1'b1, 1, 4'b0111, 0);
    idle(10);

    chk("pending_expected", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
